// File: rtl/m_ttime_pkg.sv
// Shared constants and types for the midgetv cycle/instret/timer block.
package m_ttime_pkg;

    // CSR read selector encodings
    localparam logic [1:0] SEL_CYC_LO = 2'd0;
    localparam logic [1:0] SEL_CYC_HI = 2'd1;
    localparam logic [1:0] SEL_INS_LO = 2'd2;
    localparam logic [1:0] SEL_INS_HI = 2'd3;

    // mtimecmp comes out of reset at its maximum so tirq stays quiet
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Read port state machine
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_ACK  = 2'd2
    } rd_state_e;

    // Instruction cycle count to increment: the 6-bit field encodes 64 as 0
    function automatic logic [6:0] cyc_inc(input logic [5:0] icnt);
        return (icnt == 6'd0) ? 7'd64 : {1'b0, icnt};
    endfunction

endpackage

// File: rtl/m_ttime_if.sv
// Bus between the core timing/CSR logic (master) and m_ttime (slave).
// Handshake: rd_req is a one-cycle request accepted only while the read
// state is idle; the requester then waits for the one-cycle rd_ack, during
// which rd_data is valid (and it is held afterwards until the next ack).
interface m_ttime_if;
    import m_ttime_pkg::*;

    logic        corerunning;
    logic        instr_done;
    logic [5:0]  icnt;
    logic        rd_req;
    logic [1:0]  rd_sel;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        cmp_we;
    logic        cmp_hi;
    logic [31:0] cmp_wdata;
    logic        tirq;
    rd_state_e   rd_state;

    modport master (
        output corerunning, instr_done, icnt, rd_req, rd_sel,
               cmp_we, cmp_hi, cmp_wdata,
        input  rd_ack, rd_data, tirq, rd_state
    );

    modport slave (
        input  corerunning, instr_done, icnt, rd_req, rd_sel,
               cmp_we, cmp_hi, cmp_wdata,
        output rd_ack, rd_data, tirq, rd_state
    );
endinterface

// File: rtl/m_cnt64_split.sv
// Two-phase 64-bit accumulator: lo and carry update on the event, hi absorbs
// the carry one cycle later so no 64-bit adder sits in a single path.
module m_cnt64_split (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  inc,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        cy
);
    logic [32:0] lo_sum;

    assign lo_sum = {1'b0, lo} + {26'd0, inc};

    // Low half plus carry on each event; pending carry folds into hi next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lo <= 32'd0;
            hi <= 32'd0;
            cy <= 1'b0;
        end else begin
            if (cy) begin
                hi <= hi + 32'd1;
            end
            if (en) begin
                lo <= lo_sum[31:0];
                cy <= lo_sum[32];
            end else begin
                cy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/m_ttime.sv
// Cycle (mcycle/time) and retired-instruction counters with a CSR read
// port and the machine-timer compare for midgetv.
module m_ttime
    import m_ttime_pkg::*;
#(
    parameter bit NO_INSTRET = 1'b0,
    parameter bit TIMECMP_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    m_ttime_if.slave bus
);
    logic        event_en;
    logic [31:0] cyc_lo, cyc_hi;
    logic        cyc_cy;
    logic [31:0] ins_lo, ins_hi;
    logic        ins_cy;

    rd_state_e   state;
    logic [1:0]  sel_q;
    logic [31:0] data_q;
    logic [31:0] sel_data;
    logic        sel_cy;
    logic        tirq_q;

    assign event_en = bus.instr_done & bus.corerunning;

    m_cnt64_split u_cyc (
        .clk (clk),
        .rst (rst),
        .en  (event_en),
        .inc (cyc_inc(bus.icnt)),
        .lo  (cyc_lo),
        .hi  (cyc_hi),
        .cy  (cyc_cy)
    );

    if (NO_INSTRET) begin : g_no_instret
        assign ins_lo = 32'd0;
        assign ins_hi = 32'd0;
        assign ins_cy = 1'b0;
    end else begin : g_instret
        m_cnt64_split u_ins (
            .clk (clk),
            .rst (rst),
            .en  (event_en),
            .inc (7'd1),
            .lo  (ins_lo),
            .hi  (ins_hi),
            .cy  (ins_cy)
        );
    end

    // A pending carry on the requested counter costs one extra wait cycle
    assign sel_cy = bus.rd_sel[1] ? ins_cy : cyc_cy;

    always_comb begin
        sel_data = cyc_lo;
        case (sel_q)
            SEL_CYC_LO: sel_data = cyc_lo;
            SEL_CYC_HI: sel_data = cyc_hi;
            SEL_INS_LO: sel_data = ins_lo;
            SEL_INS_HI: sel_data = ins_hi;
            default:    sel_data = cyc_lo;
        endcase
    end

    // Read FSM: latch selector, optionally wait out a carry, then acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RD_IDLE;
            sel_q  <= SEL_CYC_LO;
            data_q <= 32'd0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (bus.rd_req) begin
                        sel_q <= bus.rd_sel;
                        state <= sel_cy ? RD_WAIT : RD_ACK;
                    end
                end
                RD_WAIT: state <= RD_ACK;
                RD_ACK: begin
                    data_q <= sel_data;
                    state  <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // The ack cycle shows the live counter; afterwards the snapshot is held
    assign bus.rd_ack   = (state == RD_ACK);
    assign bus.rd_data  = (state == RD_ACK) ? sel_data : data_q;
    assign bus.rd_state = state;

    if (TIMECMP_EN) begin : g_timecmp
        logic [63:0] mtimecmp;

        // Half-word writes into mtimecmp and the registered >= compare
        always_ff @(posedge clk) begin
            if (rst) begin
                mtimecmp <= MTIMECMP_RST;
                tirq_q   <= 1'b0;
            end else begin
                if (bus.cmp_we) begin
                    if (bus.cmp_hi) begin
                        mtimecmp[63:32] <= bus.cmp_wdata;
                    end else begin
                        mtimecmp[31:0] <= bus.cmp_wdata;
                    end
                end
                tirq_q <= ({cyc_hi, cyc_lo} >= mtimecmp);
            end
        end
    end else begin : g_no_timecmp
        assign tirq_q = 1'b0;
    end

    assign bus.tirq = tirq_q;
endmodule

// File: doc/m_ttime.md
# m_ttime

Accumulates the per-instruction cycle counts delivered by the 6-bit instruction cycle counter into a 64-bit cycle counter (mcycle/time) and a 64-bit retired-instruction counter (minstret). Serves CSR reads of both counters through a simple request/acknowledge port. Drives a machine-timer interrupt from a 64-bit compare against mtimecmp. Sits between the instruction-timing logic and the CSR read/write path of midgetv.

## Interface
Parameters:
- NO_INSTRET, 0, 1 removes the minstret counter; its reads return 0.
- TIMECMP_EN, 1, 0 removes mtimecmp and the compare; tirq is tied to 0.

Ports:
- clk  in  1  Core clock; all state updates on rising edge.
- rst  in  1  Reset, synchronous, active-high.
- corerunning  in  1  High once the core is released; events are ignored while low.
- instr_done  in  1  One-cycle pulse at each instruction boundary.
- icnt  in  6  Cycles used by the finishing instruction; valid with instr_done; 0 encodes 64.
- rd_req  in  1  One-cycle CSR read request.
- rd_sel  in  2  0 cycle[31:0], 1 cycle[63:32], 2 instret[31:0], 3 instret[63:32].
- rd_ack  out  1  One-cycle pulse; rd_data valid in the same cycle.
- rd_data  out  32  Read data, held until the next ack.
- cmp_we  in  1  Write strobe for mtimecmp.
- cmp_hi  in  1  0 writes mtimecmp[31:0], 1 writes mtimecmp[63:32].
- cmp_wdata  in  32  mtimecmp write data.
- tirq  out  1  Registered timer interrupt, high while cycle >= mtimecmp.

## Operation
- Each counter is split into lo[31:0] and hi[31:0] with a carry flag cy. Per event: lo <= lo + inc and cy <= carry-out. The following cycle: hi <= hi + cy and cy is cleared. Consecutive events are legal; a new event's lo/cy update and the previous event's hi increment occur in the same cycle.
- Cycle counter: inc = icnt zero-extended, with 0 mapped to 64. Instret: inc = 1.
- An event is instr_done & corerunning. While corerunning is low, nothing counts.
- Read FSM states: IDLE, WAIT, ACK.
  - IDLE + rd_req goes to ACK if the selected counter's cy is 0, otherwise to WAIT. rd_sel is latched.
  - WAIT goes to ACK.
  - ACK samples the latched half into rd_data, pulses rd_ack, and returns to IDLE.
  - rd_req while not IDLE is ignored; requesters must wait for rd_ack.
- Snapshot rule: the value returned is the counter as of the ACK cycle, including every event up to the previous cycle.
- mtimecmp: a write replaces the selected half next cycle. tirq <= ({hi,lo} of cycle, carry settled) >= mtimecmp, evaluated every cycle.
- Reset values:
  - Counters 0, cy 0, rd_ack 0, rd_data 0, tirq 0.
  - mtimecmp 64'hFFFF_FFFF_FFFF_FFFF.
  - Read FSM in IDLE.
- rst mid-read aborts the read with no ack. rst mid-carry drops the pending carry.

## Timing
- Read latency: rd_ack 1 cycle after rd_req, or 2 cycles if the selected cy was set at request time.
- Counter visibility: lo reflects an event 1 cycle after instr_done. The full 64-bit value reflects it after 2 cycles.
- tirq reacts 1 cycle after the counter or mtimecmp changes. A compare during a pending carry uses the pre-carry hi, which gives at most one cycle of early or late assertion.
- Wrap: 64-bit counters wrap to 0 silently. A lo wrap followed by a read of hi must return the incremented hi.

## Structure
- Shared package constants:
  - rd_sel encodings (SEL_CYC_LO, SEL_CYC_HI, SEL_INS_LO, SEL_INS_HI).
  - MTIMECMP_RST.
  - The read FSM state encoding.
- Sub-module m_cnt64_split: the two-phase 64-bit accumulator with a 7-bit increment input, outputs lo, hi and cy. Instantiated once for cycle and once, conditionally, for instret.

## Test plan
- Reset, then 3 events with icnt=5 under corerunning=1 -> cycle=15 and instret=3. Reads of sel 0 and 2 ack after 1 cycle with 15 and 3.
- Preload cycle lo=32'hFFFF_FFF0, event icnt=0x20 -> lo=0x10, hi=1. A read of sel 1 issued the cycle after the event acks in 2 cycles and returns 1.
- icnt=0 event -> cycle advances by 64. Events with corerunning=0 -> no change in either counter.
- Write mtimecmp={0,100}, then events totalling 100 cycles -> tirq rises 1 cycle after the counter reaches 100. Writing cmp_hi=1 -> tirq falls 1 cycle later.
- Back-to-back events every cycle across a lo wrap -> hi increments exactly once and the final 64-bit value equals the sum of all increments.
- rst asserted while in WAIT -> no rd_ack, all counters 0, tirq 0, and the next read returns 0.
